rr_arbiter16: RTL

- 16-requester round-robin arbiter with a registered, held grant.
- Shares one downstream resource (bus/port) between 16 request lines; one grant at a time.
- Arbitration core: a combinational lowest-index-first priority encoder applied to the rotated request vector.
- Grant held until the owner releases, drops its request, or a hold timeout expires.

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_arbiter16_if.sv | 23 ++
 rtl/prio_enc16.sv | 21 ++
 rtl/rr_arbiter16.sv | 100 ++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the 16-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    function automatic logic [N_REQ-1:0] onehot16(input logic [IDX_W-1:0] idx);
        return 16'(1) << idx;
    endfunction

    // Bits at or above the round-robin pointer; used to find the next owner after ptr.
    function automatic logic [N_REQ-1:0] mask_ge(input logic [IDX_W-1:0] ptr);
        return 16'hFFFF << ptr;
    endfunction

endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The owner's release pulse is named grant_release because "release" is an SV keyword.
interface rr_arbiter16_if;

    logic                        en;
    logic [arb_pkg::N_REQ-1:0]   req;
    logic                        grant_release;
    logic [arb_pkg::N_REQ-1:0]   grant;
    logic [arb_pkg::IDX_W-1:0]   grant_idx;
    logic                        grant_valid;
    logic                        timeout;

    modport master (
        output en, req, grant_release,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  en, req, grant_release,
        output grant, grant_idx, grant_valid, timeout
    );

endinterface

// File: rtl/prio_enc16.sv
// Lowest-set-bit priority encoder; idx=0 and valid=0 for an all-zero input.
module prio_enc16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with a registered grant held until release,
// request drop, or hold timeout.
//
//   state | meaning
//   IDLE  | no owner; arbitrate when en=1 and any req is set
//   GRANT | grant held; exit on release, owner drop, or hold_cnt==MAX_HOLD
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter16_if.slave bus
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;
    logic [N_REQ-1:0] grant_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic             grant_valid_q;
    logic             timeout_q;

    logic [IDX_W-1:0] m_idx;
    logic             m_valid;
    logic [IDX_W-1:0] f_idx;
    logic             f_valid;
    logic [IDX_W-1:0] sel_idx;

    logic             rel_hit;
    logic             drop_hit;
    logic             hold_hit;

    prio_enc16 u_enc_masked (
        .vec   (bus.req & mask_ge(ptr)),
        .idx   (m_idx),
        .valid (m_valid)
    );

    prio_enc16 u_enc_full (
        .vec   (bus.req),
        .idx   (f_idx),
        .valid (f_valid)
    );

    // Nothing at or above ptr means wrap to the lowest requester overall.
    assign sel_idx  = m_valid ? m_idx : f_idx;

    assign rel_hit  = bus.grant_release;
    assign drop_hit = ~bus.req[grant_idx_q];
    assign hold_hit = (hold_cnt == HOLD_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            hold_cnt      <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && f_valid) begin
                        grant_q       <= onehot16(sel_idx);
                        grant_idx_q   <= sel_idx;
                        grant_valid_q <= 1'b1;
                        hold_cnt      <= 8'd1;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_hit || drop_hit || hold_hit) begin
                        grant_q       <= '0;
                        grant_idx_q   <= '0;
                        grant_valid_q <= 1'b0;
                        hold_cnt      <= '0;
                        ptr           <= grant_idx_q + 4'd1;
                        timeout_q     <= hold_hit && !rel_hit && !drop_hit;
                        state         <= IDLE;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = timeout_q;

endmodule
